iob_tty: RTL and testbench
==========================

Name: iob_tty

Overview:
- Teletype-style console device on the KA10 I/O bus. It is the responder end of the bus the CPU initiates.
- Decodes device select and the CONO/DATAO/CONI/DATAI strobes.
- Serialises output characters on a TX line and deserialises input characters from an RX line.
- Raises a priority interrupt on its assigned PI channel when a transfer completes.
- Its iob_in and pi outputs are OR-combined with other devices at the top level.

Parameters:
- DEV, 7'o24, device select matched against iobus_ios[3:9] (device code 120).
- DIV, 8, clock cycles per serial bit period; must be at least 4.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous reset, active-high.
- iobus_iob_reset  in  1  bus reset pulse, same effect as reset but synchronous.
- iobus_ios  in  [3:9]  device select.
- iobus_datao_clear  in  1  DATAO clear pulse.
- iobus_datao_set  in  1  DATAO set pulse.
- iobus_cono_clear  in  1  CONO clear pulse.
- iobus_cono_set  in  1  CONO set pulse.
- iobus_iob_datai  in  1  DATAI level.
- iobus_iob_coni  in  1  CONI level.
- iobus_iob_out  in  [0:35]  CPU data to devices.
- iobus_iob_in  out  [0:35]  device data to CPU; all zero unless selected and reading.
- iobus_pi  out  [1:7]  interrupt requests.
- tty_rx  in  1  serial input, idle high.
- tty_tx  out  1  serial output, idle high.

Behaviour:
- sel = (iobus_ios == DEV). All strobes are ignored when sel=0. Strobes are one-cycle pulses; levels are held for several cycles.
- Reset values (reset or iob_reset):
  - pia=0, out_busy=0, out_done=0, in_busy=0, in_done=0, overrun=0, tbuf=0, rbuf=0.
  - tty_tx=1, iobus_iob_in=0, iobus_pi=0.
  - Both shift FSMs go to IDLE and their counters to 0.
  - Reset mid-character aborts it; tty_tx returns to 1 on the next edge.
- cono_clear: pia<=0.
- cono_set: applies, all in the same cycle:
  - pia<=pia|out[33:35].
  - out[32]=1 clears out_done.
  - out[31]=1 clears in_done and overrun.
  - out[28]=1 sets out_done.
  - out[27]=1 sets in_done.
  - If a bit clears and sets the same flag, set wins.
- datao_clear: tbuf<=0.
- datao_set:
  - tbuf<=tbuf|out[28:35]; out_busy<=1; out_done<=0.
  - The TX FSM starts on the next cycle.
  - datao_set while out_busy: tbuf is updated, the character in flight is unaffected, and the new tbuf is sent after the current stop bits complete.
- CONI (iob_coni & sel), combinational: iob_in[35:33]=pia, [32]=out_done, [31]=out_busy, [30]=in_done, [29]=in_busy, [28]=overrun; all other bits 0.
- DATAI (iob_datai & sel):
  - Combinational: iob_in[28:35]=rbuf, other bits 0.
  - On the cycle the DATAI level falls while selected: in_done<=0.
- CONI and DATAI asserted together: iob_in is the OR of both.
- TX FSM: IDLE -> START -> DATA(8 bits) -> STOP(2 bit periods) -> IDLE.
  - Each state holds DIV cycles.
  - Bit order: start bit 0, data LSB first (tbuf[35] first), stop bits 1.
  - Character time is 11*DIV cycles.
  - On leaving STOP: out_busy<=0, out_done<=1.
  - If a pending datao_set occurred during the character, the FSM restarts immediately with the new tbuf and out_busy stays 1.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - rx is double-flop synchronised before use.
  - A falling edge in IDLE enters START and sets in_busy.
  - Start bit is sampled at DIV/2 cycles; if it reads 1, the FSM treats it as a glitch and returns to IDLE (in_busy=0).
  - Data bits are sampled every DIV cycles thereafter, LSB first.
  - At the stop sample: rbuf<=shift, in_busy<=0, in_done<=1, with no wait for the full stop bit.
  - If in_done was already 1 at that point: overrun<=1 and rbuf is still overwritten.
  - A stop bit of 0 (framing error) still delivers the character.
- PI:
  - iobus_pi[pia]=1 while (out_done|in_done) and pia!=0; all other bits 0.
  - Level output; drops the cycle after the flags clear.

Optional Feature:
- Macro TTY_LOOPBACK_EN.
- When defined, the RX synchroniser input is tty_tx instead of tty_rx, and tty_rx is ignored; used for self-test.
- When undefined, tty_rx is used.
- CPU-visible behaviour is otherwise identical.

Decomposition:
- Shared package iob_pkg holds:
  - CONI/CONO bit-position constants (PIA_LSB=33, OUT_DONE=32, ...).
  - The default device code constant TTY_DEV=7'o24.
  - FSM state enum (IDLE, START, DATA, STOP).
- One sub-module, tty_serial_rx: synchroniser, RX FSM, bit counter, rbuf shift register. It outputs a char_valid pulse and data[7:0].
- TX, flags and bus decode stay in iob_tty.

Test Plan:
- Reset, then CONI with sel -> iob_in=0; tty_tx=1; pi=0.
- CONO set with out=36'o000000_000003, then DATAO set with out=36'o101 (DIV=8) -> tty_tx shows 0,1,0,0,0,0,0,1,0,1,1 each 8 cycles; CONI[31] is 1 during; after 88 cycles CONI[32]=1 and pi[3]=1. CONO set with out bit 32=1 -> pi=0.
- Drive tty_rx with 8'o123 framed at DIV=8 -> in_busy, then in_done=1. DATAI -> iob_in=36'o123. After DATAI falls, in_done=0.
- Receive two characters without DATAI -> overrun=1 (CONI bit 28), rbuf holds the second character. CONO set with bit 31 clears both in_done and overrun.
- Wrong device code (ios=7'o25) with DATAO/CONO/CONI -> no state change, iob_in=0. iob_reset mid-transmit -> tty_tx=1 the next cycle, out_busy=0.
- With TTY_LOOPBACK_EN: DATAO 8'o252 -> in_done=1 after about 10.5*DIV cycles, DATAI returns 8'o252.

Source files
------------

// File: rtl/iob_pkg.sv
// Shared constants and types for KA10 I/O-bus devices: CONI/CONO bit positions
// (bus numbering, bit 35 is the LSB), the default TTY device code and serial FSM states.
package iob_pkg;

    localparam logic [6:0] TTY_DEV = 7'o24;

    // CONI status layout; PIA occupies PIA_LSB..35
    localparam int PIA_LSB  = 33;
    localparam int OUT_DONE = 32;
    localparam int OUT_BUSY = 31;
    localparam int IN_DONE  = 30;
    localparam int IN_BUSY  = 29;
    localparam int OVERRUN  = 28;

    localparam int CONO_CLR_OUT = 32;
    localparam int CONO_CLR_IN  = 31;
    localparam int CONO_SET_OUT = 28;
    localparam int CONO_SET_IN  = 27;

    localparam int CHAR_MSB = 28;
    localparam int CHAR_LSB = 35;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ser_state_e;

endpackage

// File: rtl/tty_serial_rx.sv
// TTY receiver: two-flop synchroniser, start-bit glitch rejection, mid-bit sampling
// and an LSB-first shift register. char_valid_o pulses at the stop-bit sample.
module tty_serial_rx
    import iob_pkg::*;
#(
    parameter int DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       srst,
    input  logic       rx_i,
    output logic       busy_o,
    output logic       char_valid_o,
    output logic [7:0] data_o
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] HALF_LAST = CW'(DIV / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(DIV - 1);

    ser_state_e    state_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q;
    logic          busy_q;
    logic          meta_q;
    logic          sync_q;
    logic          prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
        end else if (srst) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            meta_q <= rx_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            unique case (state_q)
                IDLE: begin
                    if (prev_q && !sync_q) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    // Line back high at mid start bit means a glitch, not a character
                    if (cnt_q == HALF_LAST) begin
                        cnt_q <= '0;
                        bit_q <= '0;
                        if (sync_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= DATA;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        shift_q <= {sync_q, shift_q[7:1]};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy_o       = busy_q;
    assign char_valid_o = (state_q == STOP) && (cnt_q == BIT_LAST);
    assign data_o       = shift_q;

endmodule

// File: rtl/iob_tty.sv
// Teletype console on the KA10 I/O bus: CONO/DATAO/CONI/DATAI decode, TX serialiser,
// flags and PI request. Define TTY_LOOPBACK_EN to feed the receiver from tty_tx.
module iob_tty
    import iob_pkg::*;
#(
    parameter logic [6:0] DEV = TTY_DEV,
    parameter int         DIV = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iobus_iob_reset,
    input  logic [3:9]  iobus_ios,
    input  logic        iobus_datao_clear,
    input  logic        iobus_datao_set,
    input  logic        iobus_cono_clear,
    input  logic        iobus_cono_set,
    input  logic        iobus_iob_datai,
    input  logic        iobus_iob_coni,
    input  logic [0:35] iobus_iob_out,
    output logic [0:35] iobus_iob_in,
    output logic [1:7]  iobus_pi,
    input  logic        tty_rx,
    output logic        tty_tx
);

    localparam int TW = $clog2(2 * DIV);
    localparam logic [TW-1:0] TX_BIT_LAST  = TW'(DIV - 1);
    localparam logic [TW-1:0] TX_STOP_LAST = TW'(2 * DIV - 1);

    logic        sel;
    logic        cono_clr, cono_set, datao_clr, datao_set;
    logic        coni_rd, datai_rd, datai_fall;
    logic [2:0]  pia_q;
    logic        out_busy_q, out_done_q, in_done_q, overrun_q;
    logic [7:0]  tbuf_q, tbuf_d, rbuf_q;
    logic        datai_rd_q;
    ser_state_e  tx_state_q;
    logic [TW-1:0] tx_cnt_q;
    logic [2:0]  tx_bit_q;
    logic [7:0]  tx_shift_q;
    logic        tx_q, tx_pend_q;
    logic        tx_last, tx_restart, tx_finish;
    logic        rx_src, in_busy, rx_valid;
    logic [7:0]  rx_data;
    logic [0:35] coni_word, datai_word;

    assign sel        = (iobus_ios == DEV);
    assign cono_clr   = iobus_cono_clear  & sel;
    assign cono_set   = iobus_cono_set    & sel;
    assign datao_clr  = iobus_datao_clear & sel;
    assign datao_set  = iobus_datao_set   & sel;
    assign coni_rd    = iobus_iob_coni    & sel;
    assign datai_rd   = iobus_iob_datai   & sel;
    assign datai_fall = datai_rd_q & ~datai_rd;

    always_comb begin
        tbuf_d = tbuf_q;
        if (datao_clr) tbuf_d = '0;
        if (datao_set) tbuf_d = tbuf_d | iobus_iob_out[CHAR_MSB:CHAR_LSB];
    end

    // A DATAO seen during a character (or on its last cycle) chains the next one
    assign tx_last    = (tx_state_q == STOP) && (tx_cnt_q == TX_STOP_LAST);
    assign tx_restart = tx_last && (tx_pend_q || datao_set);
    assign tx_finish  = tx_last && !tx_restart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_pend_q  <= 1'b0;
        end else if (iobus_iob_reset) begin
            tx_state_q <= IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_q       <= 1'b1;
            tx_pend_q  <= 1'b0;
        end else begin
            if (tx_last)                                tx_pend_q <= 1'b0;
            else if (datao_set && tx_state_q != IDLE)   tx_pend_q <= 1'b1;
            unique case (tx_state_q)
                IDLE: begin
                    if (out_busy_q) begin
                        tx_state_q <= START;
                        tx_cnt_q   <= '0;
                        tx_shift_q <= tbuf_d;
                        tx_q       <= 1'b0;
                    end
                end
                START: begin
                    if (tx_cnt_q == TX_BIT_LAST) begin
                        tx_state_q <= DATA;
                        tx_cnt_q   <= '0;
                        tx_bit_q   <= '0;
                        tx_q       <= tx_shift_q[0];
                        tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt_q == TX_BIT_LAST) begin
                        tx_cnt_q <= '0;
                        tx_bit_q <= tx_bit_q + 1'b1;
                        if (tx_bit_q == 3'd7) begin
                            tx_state_q <= STOP;
                            tx_q       <= 1'b1;
                        end else begin
                            tx_q       <= tx_shift_q[0];
                            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_last) begin
                        tx_cnt_q <= '0;
                        if (tx_restart) begin
                            tx_state_q <= START;
                            tx_shift_q <= tbuf_d;
                            tx_q       <= 1'b0;
                        end else begin
                            tx_state_q <= IDLE;
                        end
                    end else begin
                        tx_cnt_q <= tx_cnt_q + 1'b1;
                    end
                end
                default: tx_state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pia_q      <= '0;
            out_busy_q <= 1'b0;
            out_done_q <= 1'b0;
            in_done_q  <= 1'b0;
            overrun_q  <= 1'b0;
            tbuf_q     <= '0;
            rbuf_q     <= '0;
            datai_rd_q <= 1'b0;
        end else if (iobus_iob_reset) begin
            pia_q      <= '0;
            out_busy_q <= 1'b0;
            out_done_q <= 1'b0;
            in_done_q  <= 1'b0;
            overrun_q  <= 1'b0;
            tbuf_q     <= '0;
            rbuf_q     <= '0;
            datai_rd_q <= 1'b0;
        end else begin
            tbuf_q     <= tbuf_d;
            datai_rd_q <= datai_rd;
            pia_q      <= (cono_clr ? 3'b000 : pia_q)
                        | (cono_set ? iobus_iob_out[PIA_LSB:35] : 3'b000);

            if (tx_finish) out_busy_q <= 1'b0;
            if (datao_set) out_busy_q <= 1'b1;

            // Later statements win: CONO set bits override the clears
            if (tx_finish)                               out_done_q <= 1'b1;
            if (datao_set)                               out_done_q <= 1'b0;
            if (cono_set && iobus_iob_out[CONO_CLR_OUT]) out_done_q <= 1'b0;
            if (cono_set && iobus_iob_out[CONO_SET_OUT]) out_done_q <= 1'b1;

            if (datai_fall)                              in_done_q <= 1'b0;
            if (rx_valid)                                in_done_q <= 1'b1;
            if (cono_set && iobus_iob_out[CONO_CLR_IN])  in_done_q <= 1'b0;
            if (cono_set && iobus_iob_out[CONO_SET_IN])  in_done_q <= 1'b1;

            if (rx_valid && in_done_q)                   overrun_q <= 1'b1;
            if (cono_set && iobus_iob_out[CONO_CLR_IN])  overrun_q <= 1'b0;

            if (rx_valid) rbuf_q <= rx_data;
        end
    end

`ifdef TTY_LOOPBACK_EN
    assign rx_src = tx_q;
`else
    assign rx_src = tty_rx;
`endif

    tty_serial_rx #(
        .DIV (DIV)
    ) u_rx (
        .clk          (clk),
        .rst          (reset),
        .srst         (iobus_iob_reset),
        .rx_i         (rx_src),
        .busy_o       (in_busy),
        .char_valid_o (rx_valid),
        .data_o       (rx_data)
    );

    always_comb begin
        coni_word                 = '0;
        coni_word[PIA_LSB:35]     = pia_q;
        coni_word[OUT_DONE]       = out_done_q;
        coni_word[OUT_BUSY]       = out_busy_q;
        coni_word[IN_DONE]        = in_done_q;
        coni_word[IN_BUSY]        = in_busy;
        coni_word[OVERRUN]        = overrun_q;
        datai_word                = '0;
        datai_word[CHAR_MSB:CHAR_LSB] = rbuf_q;
        iobus_iob_in = (coni_rd ? coni_word : '0) | (datai_rd ? datai_word : '0);
    end

    for (genvar gi = 1; gi <= 7; gi++) begin : g_pi
        assign iobus_pi[gi] = (out_done_q | in_done_q) && (pia_q == 3'(gi));
    end

    assign tty_tx = tx_q;

endmodule

// File: tb/tb_iob_tty.sv
// Scoreboard bench for iob_tty: bus reads and TX frames queue their expected values;
// two monitors pop and compare as the DUT presents data on iob_in/pi and tty_tx.
module tb_iob_tty;

    localparam int         DIV     = 8;
    localparam logic [6:0] DEV     = 7'o24;
    localparam logic [6:0] BAD_DEV = 7'o25;
    localparam int K_CONO_CLR  = 0;
    localparam int K_CONO_SET  = 1;
    localparam int K_DATAO_CLR = 2;
    localparam int K_DATAO_SET = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        iob_reset = 1'b0;
    logic [3:9]  ios = DEV;
    logic        datao_clear = 1'b0, datao_set = 1'b0, cono_clear = 1'b0, cono_set = 1'b0;
    logic        datai = 1'b0, coni = 1'b0;
    logic [0:35] out_w = '0;
    logic [0:35] iob_in;
    logic [1:7]  pi;
    logic        rx = 1'b1;
    logic        tx;

    int checks = 0;
    int errors = 0;
    logic mon_req = 1'b0;
    logic tx_mon_en = 1'b1;

    typedef struct {
        string       name;
        logic [35:0] exp_in;
        logic [6:0]  exp_pi;
        bit          chk_tx;
    } rd_exp_t;

    rd_exp_t    rd_q[$];
    rd_exp_t    mon_e;
    logic [7:0] tx_exp_q[$];

    always #5 clk = ~clk;

    iob_tty #(.DEV(DEV), .DIV(DIV)) dut (
        .clk               (clk),
        .reset             (reset),
        .iobus_iob_reset   (iob_reset),
        .iobus_ios         (ios),
        .iobus_datao_clear (datao_clear),
        .iobus_datao_set   (datao_set),
        .iobus_cono_clear  (cono_clear),
        .iobus_cono_set    (cono_set),
        .iobus_iob_datai   (datai),
        .iobus_iob_coni    (coni),
        .iobus_iob_out     (out_w),
        .iobus_iob_in      (iob_in),
        .iobus_pi          (pi),
        .tty_rx            (rx),
        .tty_tx            (tx)
    );

    // Bus read monitor
    always @(negedge clk) begin
        if (mon_req) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_underflow: read seen with no expectation queued, iob_in=%o", iob_in);
            end else begin
                mon_e = rd_q.pop_front();
                if (iob_in !== mon_e.exp_in || pi !== mon_e.exp_pi || (mon_e.chk_tx && tx !== 1'b1)) begin
                    errors++;
                    $display("FAIL %s: got iob_in=%o pi=%b tx=%b, expected iob_in=%o pi=%b%s",
                             mon_e.name, iob_in, pi, tx, mon_e.exp_in, mon_e.exp_pi,
                             mon_e.chk_tx ? " tx=1" : "");
                end else begin
                    $display("check %s ok: iob_in=%o pi=%b", mon_e.name, iob_in, pi);
                end
            end
        end
    end

    // TX frame monitor: samples mid-bit, DIV cycles apart
    initial begin : tx_mon
        logic       prev;
        logic [10:0] bits;
        logic [7:0] exp_ch;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (prev && tx === 1'b0 && tx_mon_en) begin
                repeat (DIV / 2 - 1) @(negedge clk);
                bits[0] = tx;
                for (int i = 1; i < 11; i++) begin
                    repeat (DIV) @(negedge clk);
                    bits[i] = tx;
                end
                checks++;
                if (tx_exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL tx_frame: unexpected frame bits=%b", bits);
                end else begin
                    exp_ch = tx_exp_q.pop_front();
                    if (bits !== {2'b11, exp_ch, 1'b0}) begin
                        errors++;
                        $display("FAIL tx_frame: got bits=%b, expected %b", bits, {2'b11, exp_ch, 1'b0});
                    end else begin
                        $display("check tx_frame ok: char=%o", exp_ch);
                    end
                end
                prev = 1'b1;
            end else begin
                prev = tx;
            end
        end
    end

    task automatic strobe(input int kind, input logic [6:0] dev, input logic [35:0] data);
        @(posedge clk); #1;
        ios   = dev;
        out_w = data;
        case (kind)
            K_CONO_CLR:  cono_clear  = 1'b1;
            K_CONO_SET:  cono_set    = 1'b1;
            K_DATAO_CLR: datao_clear = 1'b1;
            default:     datao_set   = 1'b1;
        endcase
        @(posedge clk); #1;
        cono_clear = 1'b0; cono_set = 1'b0; datao_clear = 1'b0; datao_set = 1'b0;
        ios   = DEV;
        out_w = '0;
    endtask

    task automatic bus_read(input bit do_coni, input bit do_datai, input logic [6:0] dev,
                            input logic [35:0] exp_in, input logic [6:0] exp_pi,
                            input bit chk_tx, input string name);
        rd_exp_t e;
        e.name = name; e.exp_in = exp_in; e.exp_pi = exp_pi; e.chk_tx = chk_tx;
        rd_q.push_back(e);
        @(posedge clk); #1;
        ios = dev; coni = do_coni; datai = do_datai; mon_req = 1'b1;
        @(posedge clk); #1;
        mon_req = 1'b0;
        @(posedge clk); #1;
        coni = 1'b0; datai = 1'b0; ios = DEV;
    endtask

    task automatic send_rx(input logic [7:0] ch, input bit stop);
        logic [9:0] frame;
        frame = {stop, ch, 1'b0};
        @(posedge clk); #1;
        for (int i = 0; i < 10; i++) begin
            rx = frame[i];
            repeat (DIV) @(posedge clk);
            #1;
        end
        rx = 1'b1;
    endtask

    task automatic send_tx(input logic [7:0] ch);
        tx_exp_q.push_back(ch);
        strobe(K_DATAO_SET, DEV, {28'd0, ch});
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        bus_read(1, 0, DEV, 36'o0, 7'b0, 1, "reset_coni");
        bus_read(0, 1, DEV, 36'o0, 7'b0, 1, "reset_datai");
`ifdef TTY_LOOPBACK_EN
        send_tx(8'o252);
        repeat (130) @(posedge clk);
        bus_read(1, 0, DEV, 36'o50, 7'b0, 1, "lb_coni");
        bus_read(0, 1, DEV, 36'o252, 7'b0, 1, "lb_datai");
`else
        strobe(K_CONO_SET, DEV, 36'o3);
        bus_read(1, 0, DEV, 36'o3, 7'b0, 1, "cono_pia");
        send_tx(8'o101);
        repeat (20) @(posedge clk);
        bus_read(1, 0, DEV, 36'o23, 7'b0, 0, "tx_busy");
        repeat (100) @(posedge clk);
        bus_read(1, 0, DEV, 36'o13, 7'b0010000, 1, "tx_done_pi3");
        strobe(K_CONO_SET, DEV, 36'o10);
        bus_read(1, 0, DEV, 36'o3, 7'b0, 1, "clr_out_done");

        fork
            send_rx(8'o123, 1'b1);
            begin
                repeat (30) @(posedge clk);
                bus_read(1, 0, DEV, 36'o103, 7'b0, 1, "rx_busy");
            end
        join
        bus_read(1, 0, DEV, 36'o43, 7'b0010000, 1, "rx_done");
        bus_read(0, 1, DEV, 36'o123, 7'b0010000, 1, "datai_rbuf");
        bus_read(1, 0, DEV, 36'o3, 7'b0, 1, "datai_clears_done");

        @(posedge clk); #1 rx = 1'b0;
        repeat (2) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        bus_read(1, 0, DEV, 36'o3, 7'b0, 1, "rx_glitch");

        send_rx(8'o065, 1'b1);
        send_rx(8'o142, 1'b1);
        bus_read(1, 0, DEV, 36'o243, 7'b0010000, 1, "overrun");
        strobe(K_CONO_SET, DEV, 36'o20);
        bus_read(1, 0, DEV, 36'o3, 7'b0, 1, "clr_in_overrun");
        bus_read(0, 1, DEV, 36'o142, 7'b0, 1, "overrun_rbuf");

        strobe(K_CONO_SET, DEV, 36'o210);
        bus_read(1, 0, DEV, 36'o13, 7'b0010000, 1, "set_wins_out");
        strobe(K_CONO_SET, DEV, 36'o420);
        bus_read(1, 0, DEV, 36'o53, 7'b0010000, 1, "set_wins_in");
        strobe(K_CONO_SET, DEV, 36'o30);
        bus_read(1, 0, DEV, 36'o3, 7'b0, 1, "clr_both");

        strobe(K_CONO_CLR, DEV, 36'o0);
        strobe(K_CONO_SET, DEV, 36'o200);
        bus_read(1, 0, DEV, 36'o10, 7'b0, 1, "pia0_no_pi");
        strobe(K_CONO_SET, DEV, 36'o15);
        bus_read(1, 0, DEV, 36'o5, 7'b0, 1, "pia5");

        strobe(K_DATAO_SET, BAD_DEV, 36'o377);
        strobe(K_CONO_SET, BAD_DEV, 36'o277);
        strobe(K_CONO_CLR, BAD_DEV, 36'o0);
        bus_read(1, 1, BAD_DEV, 36'o0, 7'b0, 1, "bad_dev_read");
        bus_read(1, 0, DEV, 36'o5, 7'b0, 1, "bad_dev_nochange");

        strobe(K_DATAO_CLR, DEV, 36'o0);
        send_tx(8'o002);
        repeat (100) @(posedge clk);
        bus_read(1, 0, DEV, 36'o15, 7'b0000100, 1, "tx2_done");

        strobe(K_DATAO_CLR, DEV, 36'o0);
        send_tx(8'o061);
        repeat (20) @(posedge clk);
        strobe(K_DATAO_CLR, DEV, 36'o0);
        send_tx(8'o116);
        repeat (80) @(posedge clk);
        bus_read(1, 0, DEV, 36'o25, 7'b0, 0, "tx_pend_busy");
        repeat (100) @(posedge clk);
        bus_read(1, 0, DEV, 36'o15, 7'b0000100, 1, "tx_pend_done");

        send_rx(8'o321, 1'b0);
        bus_read(0, 1, DEV, 36'o321, 7'b0000100, 1, "framing_datai");
        bus_read(1, 0, DEV, 36'o15, 7'b0000100, 1, "framing_cleared");

        tx_mon_en = 1'b0;
        strobe(K_DATAO_CLR, DEV, 36'o0);
        strobe(K_DATAO_SET, DEV, 36'o0);
        repeat (30) @(posedge clk);
        #1 iob_reset = 1'b1;
        @(posedge clk); #1 iob_reset = 1'b0;
        bus_read(1, 0, DEV, 36'o0, 7'b0, 1, "iob_reset_mid_tx");
        repeat (100) @(posedge clk);
        bus_read(1, 0, DEV, 36'o0, 7'b0, 1, "iob_reset_idle");
        tx_mon_en = 1'b1;
`endif
        repeat (20) @(posedge clk);
        checks++;
        if (rd_q.size() != 0 || tx_exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d reads and %0d tx frames still expected, required 0 and 0",
                     rd_q.size(), tx_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
